// File: rtl/vldrdy_collector_if.sv
// Handshake bundle for the two-into-one valid/ready join.
// The environment drives through master; the collector sits on slave.
interface vldrdy_collector_if #(
   parameter int W1    = 8,
   parameter int W2    = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              up1_valid;
   logic              up1_ready;
   logic [W1-1:0]     up1_data;
   logic              up2_valid;
   logic              up2_ready;
   logic [W2-1:0]     up2_data;
   logic              dn_valid;
   logic              dn_ready;
   logic [W1+W2-1:0]  dn_data;
   logic [CW-1:0]     up1_count;
   logic [CW-1:0]     up2_count;

   modport master (
      output up1_valid, up1_data, up2_valid, up2_data, dn_ready,
      input  up1_ready, up2_ready, dn_valid, dn_data, up1_count, up2_count
   );

   modport slave (
      input  up1_valid, up1_data, up2_valid, up2_data, dn_ready,
      output up1_ready, up2_ready, dn_valid, dn_data, up1_count, up2_count
   );
endinterface

// File: rtl/vldrdy_collector.sv
// Valid/ready join: one FIFO per upstream channel, downstream fires when both heads exist.
// All handshake outputs come from registered state, so dn_ready never reaches up*_ready.
module vldrdy_collector #(
   parameter int W1    = 8,
   parameter int W2    = 8,
   parameter int DEPTH = 4
) (
   input  logic                clock,
   input  logic                resetn,
   vldrdy_collector_if.slave   bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);

   logic [W1-1:0] mem1 [DEPTH];
   logic [W2-1:0] mem2 [DEPTH];
   logic [AW-1:0] wptr1, wptr2, rptr1, rptr2;
   logic [CW-1:0] cnt1, cnt2;
   logic          up1_fire, up2_fire, dn_fire;

   assign bus.up1_ready = (cnt1 != CW'(DEPTH));
   assign bus.up2_ready = (cnt2 != CW'(DEPTH));
   assign bus.dn_valid  = (cnt1 != '0) && (cnt2 != '0);
   assign bus.dn_data   = {mem2[rptr2], mem1[rptr1]};
   assign bus.up1_count = cnt1;
   assign bus.up2_count = cnt2;

   assign up1_fire = bus.up1_valid & bus.up1_ready;
   assign up2_fire = bus.up2_valid & bus.up2_ready;
   assign dn_fire  = bus.dn_valid  & bus.dn_ready;

   // Storage is deliberately left unreset; count alone says what is valid.
   always_ff @(posedge clock) begin
      if (up1_fire) mem1[wptr1] <= bus.up1_data;
      if (up2_fire) mem2[wptr2] <= bus.up2_data;
   end

   // Pointers are AW bits wide and DEPTH is a power of two, so they wrap for free.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wptr1 <= '0;
         wptr2 <= '0;
         rptr1 <= '0;
         rptr2 <= '0;
         cnt1  <= '0;
         cnt2  <= '0;
      end else begin
         if (up1_fire) wptr1 <= wptr1 + AW'(1);
         if (up2_fire) wptr2 <= wptr2 + AW'(1);
         if (dn_fire) begin
            rptr1 <= rptr1 + AW'(1);
            rptr2 <= rptr2 + AW'(1);
         end
         case ({up1_fire, dn_fire})
            2'b10:   cnt1 <= cnt1 + CW'(1);
            2'b01:   cnt1 <= cnt1 - CW'(1);
            default: cnt1 <= cnt1;
         endcase
         case ({up2_fire, dn_fire})
            2'b10:   cnt2 <= cnt2 + CW'(1);
            2'b01:   cnt2 <= cnt2 - CW'(1);
            default: cnt2 <= cnt2;
         endcase
      end
   end
endmodule

// File: tb/tb_vldrdy_collector.sv
// Directed bench for vldrdy_collector with W1=W2=8, DEPTH=4.
module tb_vldrdy_collector;
   logic clock;
   logic resetn;
   int   n_checks;
   int   n_err;

   vldrdy_collector_if #(.W1(8), .W2(8), .DEPTH(4)) bus ();

   vldrdy_collector #(.W1(8), .W2(8), .DEPTH(4)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_checks      = 0;
      n_err         = 0;
      resetn        = 1'b0;
      bus.up1_valid = 1'b0;
      bus.up1_data  = '0;
      bus.up2_valid = 1'b0;
      bus.up2_data  = '0;
      bus.dn_ready  = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      tick();

      chk("rst_up1_ready", 32'(bus.up1_ready), 32'd1);
      chk("rst_up2_ready", 32'(bus.up2_ready), 32'd1);
      chk("rst_dn_valid",  32'(bus.dn_valid),  32'd0);
      chk("rst_count1",    32'(bus.up1_count), 32'd0);
      chk("rst_count2",    32'(bus.up2_count), 32'd0);

      // basic join
      bus.dn_ready  = 1'b1;
      bus.up1_valid = 1'b1; bus.up1_data = 8'hA5;
      bus.up2_valid = 1'b1; bus.up2_data = 8'h3C;
      tick();
      bus.up1_valid = 1'b0; bus.up2_valid = 1'b0;
      chk("join_valid", 32'(bus.dn_valid), 32'd1);
      chk("join_data",  32'(bus.dn_data),  32'h3CA5);
      chk("join_cnt1",  32'(bus.up1_count), 32'd1);
      tick();
      chk("join_done_valid", 32'(bus.dn_valid),  32'd0);
      chk("join_done_cnt1",  32'(bus.up1_count), 32'd0);
      chk("join_done_cnt2",  32'(bus.up2_count), 32'd0);

      // skew until ch1 is full
      for (int i = 1; i <= 4; i++) begin
         bus.up1_valid = 1'b1; bus.up1_data = 8'(i);
         tick();
      end
      chk("skew_cnt1",     32'(bus.up1_count), 32'd4);
      chk("skew_ready1",   32'(bus.up1_ready), 32'd0);
      chk("skew_dn_valid", 32'(bus.dn_valid),  32'd0);
      bus.up1_data = 8'h05;
      tick();
      chk("skew_stall_cnt1", 32'(bus.up1_count), 32'd4);
      bus.up2_valid = 1'b1; bus.up2_data = 8'h10;
      tick();
      bus.up2_valid = 1'b0;
      chk("skew_dn_valid2", 32'(bus.dn_valid),  32'd1);
      chk("skew_dn_data",   32'(bus.dn_data),   32'h1001);
      chk("skew_ready1_fire", 32'(bus.up1_ready), 32'd0);
      tick();
      chk("skew_ready1_rise", 32'(bus.up1_ready), 32'd1);
      chk("skew_cnt1_pop",    32'(bus.up1_count), 32'd3);
      chk("skew_cnt2_pop",    32'(bus.up2_count), 32'd0);
      tick();
      bus.up1_valid = 1'b0;
      chk("skew_accept5", 32'(bus.up1_count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         bus.up2_valid = 1'b1; bus.up2_data = 8'(8'h11 + i);
         tick();
         chk("skew_drain_valid", 32'(bus.dn_valid), 32'd1);
         chk("skew_drain_data",  32'(bus.dn_data), {16'h0, 8'(8'h11 + i), 8'(8'h02 + i)});
      end
      bus.up2_valid = 1'b0;
      tick();
      chk("skew_empty_cnt1", 32'(bus.up1_count), 32'd0);
      chk("skew_empty_cnt2", 32'(bus.up2_count), 32'd0);

      // backpressure with two tokens each
      bus.dn_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.up1_valid = 1'b1; bus.up1_data = 8'(8'h21 + i);
         bus.up2_valid = 1'b1; bus.up2_data = 8'(8'h31 + i);
         tick();
      end
      bus.up1_valid = 1'b0; bus.up2_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.dn_valid),  32'd1);
         chk("bp_data",  32'(bus.dn_data),   32'h3121);
         chk("bp_cnt1",  32'(bus.up1_count), 32'd2);
         chk("bp_cnt2",  32'(bus.up2_count), 32'd2);
         tick();
      end
      bus.dn_ready = 1'b1;
      tick();
      chk("bp_rel_valid", 32'(bus.dn_valid),  32'd1);
      chk("bp_rel_data",  32'(bus.dn_data),   32'h3222);
      chk("bp_rel_cnt1",  32'(bus.up1_count), 32'd1);
      tick();
      chk("bp_done_valid", 32'(bus.dn_valid),  32'd0);
      chk("bp_done_cnt1",  32'(bus.up1_count), 32'd0);

      // streaming across several pointer wraps
      for (int i = 0; i < 20; i++) begin
         bus.up1_valid = 1'b1; bus.up1_data = 8'(i);
         bus.up2_valid = 1'b1; bus.up2_data = 8'(8'h80 + i);
         tick();
         chk("str_valid", 32'(bus.dn_valid), 32'd1);
         chk("str_data",  32'(bus.dn_data), {16'h0, 8'(8'h80 + i), 8'(i)});
         chk("str_cnt1",  32'(bus.up1_count), 32'd1);
         chk("str_cnt2",  32'(bus.up2_count), 32'd1);
      end
      bus.up1_valid = 1'b0; bus.up2_valid = 1'b0;
      tick();
      chk("str_end_cnt1", 32'(bus.up1_count), 32'd0);
      chk("str_end_valid", 32'(bus.dn_valid), 32'd0);

      // simultaneous push/pop at full
      bus.dn_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.up1_valid = 1'b1; bus.up1_data = 8'(8'h40 + i);
         bus.up2_valid = 1'b1; bus.up2_data = 8'(8'h50 + i);
         tick();
      end
      bus.up2_valid = 1'b0;
      bus.up1_data  = 8'h44;
      bus.dn_ready  = 1'b1;
      chk("full_cnt1",   32'(bus.up1_count), 32'd4);
      chk("full_cnt2",   32'(bus.up2_count), 32'd4);
      chk("full_ready1", 32'(bus.up1_ready), 32'd0);
      chk("full_ready2", 32'(bus.up2_ready), 32'd0);
      chk("full_head",   32'(bus.dn_data),   32'h5040);
      tick();
      chk("full_pop_cnt1",   32'(bus.up1_count), 32'd3);
      chk("full_pop_cnt2",   32'(bus.up2_count), 32'd3);
      chk("full_pop_ready1", 32'(bus.up1_ready), 32'd1);
      chk("full_pop_data",   32'(bus.dn_data),   32'h5141);
      tick();
      bus.up1_valid = 1'b0;
      bus.dn_ready  = 1'b0;
      chk("full_pp_cnt1", 32'(bus.up1_count), 32'd3);
      chk("full_pp_cnt2", 32'(bus.up2_count), 32'd2);
      chk("full_pp_data", 32'(bus.dn_data),   32'h5242);

      // async reset with 3 tokens buffered in ch1
      @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_cnt1",   32'(bus.up1_count), 32'd0);
      chk("arst_cnt2",   32'(bus.up2_count), 32'd0);
      chk("arst_valid",  32'(bus.dn_valid),  32'd0);
      chk("arst_ready1", 32'(bus.up1_ready), 32'd1);
      tick();
      resetn = 1'b1;
      tick();
      chk("arst_rel_valid", 32'(bus.dn_valid),  32'd0);
      chk("arst_rel_cnt1",  32'(bus.up1_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/vldrdy_collector.md
Name: vldrdy_collector

Overview:
- Valid/ready join: collects one token from each of two upstream channels and emits one combined token downstream. It is the converging counterpart to the fork that splits one upstream into two downstreams.
- Each upstream channel has its own DEPTH-entry FIFO, so producers can run skewed by up to DEPTH tokens.
- Downstream fires only when both FIFOs hold a token; the two heads are popped together.
- No combinational path from dn_ready to any up*_ready.

Parameters:
- W1, 8, payload width of channel 1 (>=1)
- W2, 8, payload width of channel 2 (>=1)
- DEPTH, 4, entries per FIFO; power of two, >=2
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clock  input  1  single clock, rising edge
- resetn  input  1  asynchronous active-low reset
- up1_valid  input  1  channel 1 token present
- up1_ready  output  1  channel 1 FIFO can accept
- up1_data  input  W1  channel 1 payload
- up2_valid  input  1  channel 2 token present
- up2_ready  output  1  channel 2 FIFO can accept
- up2_data  input  W2  channel 2 payload
- dn_valid  output  1  joined token present
- dn_ready  input  1  downstream accepts
- dn_data  output  W1+W2  {ch2 head, ch1 head}; ch1 head in bits [W1-1:0]
- up1_count  output  CW  channel 1 FIFO occupancy
- up2_count  output  CW  channel 2 FIFO occupancy

Behaviour:
- Reset (async assert, sync release on clock): counts=0, read/write pointers=0, dn_valid=0, up1_ready=up2_ready=1. FIFO storage is not reset; dn_data is don't-care while dn_valid=0.
- Fire definitions: upN_fire = upN_valid & upN_ready; dn_fire = dn_valid & dn_ready.
- upN_ready = (upN_count != DEPTH), from registered state only. When full, a same-cycle dn_fire does NOT raise upN_ready (no bypass).
- dn_valid = (up1_count != 0) & (up2_count != 0), from registered state only. dn_valid does not depend on dn_ready.
- dn_data comes from registered FIFO heads (read-pointer entries).
- Push: on upN_fire, write upN_data at wptrN and increment wptrN (mod DEPTH).
- Pop: on dn_fire, increment rptr1 and rptr2 together.
- Per-FIFO count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, with pointers advanced correctly.
- Latency: a token pushed at edge k is visible at the head from cycle k+1. With the other FIFO non-empty, dn_valid asserts the cycle after the push edge. No zero-cycle pass-through.
- Throughput: one joined token per cycle when both producers stream and dn_ready=1, once both FIFOs are non-empty.
- Ordering: each channel is strictly FIFO. The i-th dn token pairs the i-th ch1 token with the i-th ch2 token.
- Skew: one channel may run ahead by up to DEPTH tokens. It then stalls (ready=0) until a dn_fire frees an entry.
- Wrap-around: pointers wrap at DEPTH with no bubble. Count alone distinguishes full from empty.
- Stability: while dn_valid=1 and dn_ready=0, dn_valid and dn_data stay constant.
- Upstream protocol: upstream must hold valid/data until fire. The block does not check this.
- Reset mid-operation: all buffered tokens are discarded immediately. Outputs return to reset values asynchronously.
- Empty/stall: with one FIFO empty, dn_valid=0 regardless of the other's count. Pushes into the non-empty FIFO continue until it is full.

Test Plan:
- Reset then idle: after release, up1_ready=up2_ready=1, dn_valid=0, counts=0. Hold resetn low mid-stream with 3 tokens buffered -> counts=0 and dn_valid=0 immediately.
- Basic join: push up1_data=0xA5 and up2_data=0x3C in the same cycle, dn_ready=1 -> next cycle dn_valid=1 with dn_data=0x3CA5. The cycle after, counts=0 and dn_valid=0.
- Skew/full: DEPTH=4, drive ch1 tokens 0x01..0x05 with up2_valid=0 -> up1_count reaches 4 and up1_ready=0, so 0x05 stalls. Then push ch2 0x10 -> dn_data=0x1001. On that dn_fire, up1_ready is still 0 in that cycle and rises the next cycle, after which 0x05 is accepted.
- Backpressure: both FIFOs hold 2 tokens, dn_ready=0 for 5 cycles -> dn_valid=1 and dn_data stable throughout, counts stay 2. Release -> 2 tokens out on consecutive cycles.
- Streaming/wrap: push 20 tokens on each channel back-to-back (ch1=i, ch2=0x80+i), dn_ready=1 -> 20 outputs in order {0x80+i, i}, one per cycle after first, counts never exceed 1. Pointers wrap 5 times with no loss.
- Simultaneous push/pop at full: both FIFOs full, then dn_ready=1 with up1_valid=1 -> upN_ready=0 that cycle, count goes 4->3, and the push is accepted next cycle with count staying 3.
